// File: rtl/data_mem_io_pkg.sv
// Shared constants for the core's data-memory / I/O stage: memory sizes,
// the I/O address map and the address decoder used by the load/store path.
package data_mem_io_pkg;

    localparam int DBITS        = 32;
    localparam int DMEMADDRBITS = 13;
    localparam int DMEMWORDBITS = 2;
    localparam int DMEMWORDS    = 2048;

    localparam logic [3:0]  IO_REGION    = 4'hF;
    localparam logic [31:0] ADDR_HEX     = 32'hF000_0000;
    localparam logic [31:0] ADDR_LEDR    = 32'hF000_0004;
    localparam logic [31:0] ADDR_LEDG    = 32'hF000_0008;
    localparam logic [31:0] ADDR_KEY     = 32'hF000_0010;
    localparam logic [31:0] ADDR_SW      = 32'hF000_0014;
    localparam logic [31:0] ADDR_KEYCTRL = 32'hF000_0018;

    typedef enum logic [2:0] {
        SEL_RAM,
        SEL_HEX,
        SEL_LEDR,
        SEL_LEDG,
        SEL_KEY,
        SEL_SW,
        SEL_KEYCTRL,
        SEL_NONE
    } mem_sel_e;

    // Takes the word address (byte offset already dropped); unmapped I/O words give SEL_NONE.
    function automatic mem_sel_e decode_addr(input logic [DBITS-DMEMWORDBITS-1:0] word_addr);
        mem_sel_e sel;
        if (word_addr[DBITS-DMEMWORDBITS-1 -: 4] != IO_REGION) begin
            sel = SEL_RAM;
        end else begin
            case (word_addr)
                ADDR_HEX[DBITS-1:DMEMWORDBITS]:     sel = SEL_HEX;
                ADDR_LEDR[DBITS-1:DMEMWORDBITS]:    sel = SEL_LEDR;
                ADDR_LEDG[DBITS-1:DMEMWORDBITS]:    sel = SEL_LEDG;
                ADDR_KEY[DBITS-1:DMEMWORDBITS]:     sel = SEL_KEY;
                ADDR_SW[DBITS-1:DMEMWORDBITS]:      sel = SEL_SW;
                ADDR_KEYCTRL[DBITS-1:DMEMWORDBITS]: sel = SEL_KEYCTRL;
                default:                            sel = SEL_NONE;
            endcase
        end
        return sel;
    endfunction

endpackage

// File: rtl/seven_seg_decoder.sv
// Hex nibble to seven-segment pattern, active-low, bit order g..a.
module seven_seg_decoder (
    input  logic [3:0] i_nibble,
    output logic [6:0] o_seg
);

    always_comb begin
        o_seg = 7'b1111111;
        case (i_nibble)
            4'h0: o_seg = 7'b1000000;
            4'h1: o_seg = 7'b1111001;
            4'h2: o_seg = 7'b0100100;
            4'h3: o_seg = 7'b0110000;
            4'h4: o_seg = 7'b0011001;
            4'h5: o_seg = 7'b0010010;
            4'h6: o_seg = 7'b0000010;
            4'h7: o_seg = 7'b1111000;
            4'h8: o_seg = 7'b0000000;
            4'h9: o_seg = 7'b0010000;
            4'hA: o_seg = 7'b0001000;
            4'hB: o_seg = 7'b0000011;
            4'hC: o_seg = 7'b1000110;
            4'hD: o_seg = 7'b0100001;
            4'hE: o_seg = 7'b0000110;
            4'hF: o_seg = 7'b0001110;
            default: o_seg = 7'b1111111;
        endcase
    end

endmodule

// File: rtl/data_mem_io.sv
// Data RAM plus memory-mapped board I/O for the single-cycle core: combinational
// loads, clocked stores, HEX/LED output registers, KEY edge capture and SW debounce.
module data_mem_io
    import data_mem_io_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 100000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [DBITS-1:0] memAddr,
    input  logic             memWrtEn,
    input  logic [DBITS-1:0] memWrtData,
    output logic [DBITS-1:0] memRdData,
    input  logic [3:0]       keyIn,
    input  logic [9:0]       swIn,
    output logic [6:0]       hex0,
    output logic [6:0]       hex1,
    output logic [6:0]       hex2,
    output logic [6:0]       hex3,
    output logic [9:0]       ledr,
    output logic [7:0]       ledg
);

    localparam int              CNTW     = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNTW-1:0] CNT_LAST = CNTW'(DEBOUNCE_CYCLES - 1);

    mem_sel_e                               w_sel;
    logic [DMEMADDRBITS-DMEMWORDBITS-1:0]   w_word_idx;
    logic [DBITS-1:0]                       w_ram_rd;
    logic [3:0]                             w_key_now;
    logic [3:0]                             w_key_rise;
    logic [3:0]                             w_key_clr;
    logic                                   w_unused;

    logic [DBITS-1:0]  r_ram [DMEMWORDS];
    logic [15:0]       r_hex;
    logic [9:0]        r_ledr;
    logic [7:0]        r_ledg;
    logic [3:0]        r_key_sync1;
    logic [3:0]        r_key_sync2;
    logic [3:0]        r_key_prev;
    logic [3:0]        r_key_flags;
    logic [9:0]        r_sw_sync1;
    logic [9:0]        r_sw_sync;
    logic [9:0]        r_sw_last;
    logic [9:0]        r_sw_stable;
    logic [CNTW-1:0]   r_dbcnt;

    assign w_sel      = decode_addr(memAddr[DBITS-1:DMEMWORDBITS]);
    assign w_word_idx = memAddr[DMEMADDRBITS-1:DMEMWORDBITS];
    assign w_unused   = ^{memAddr[DMEMWORDBITS-1:0], memWrtData[DBITS-1:16]};

    // Asynchronous read so a load completes in the same cycle; a store lands on the edge.
    assign w_ram_rd = r_ram[w_word_idx];

    always_ff @(posedge clk) begin
        if (memWrtEn && w_sel == SEL_RAM) begin
            r_ram[w_word_idx] <= memWrtData;
        end
    end

    assign w_key_now  = ~r_key_sync2;
    assign w_key_rise = w_key_now & ~r_key_prev;
    assign w_key_clr  = (memWrtEn && w_sel == SEL_KEYCTRL) ? memWrtData[3:0] : 4'h0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_hex       <= '0;
            r_ledr      <= '0;
            r_ledg      <= '0;
            r_key_sync1 <= 4'hF;
            r_key_sync2 <= 4'hF;
            r_key_prev  <= '0;
            r_key_flags <= '0;
        end else begin
            if (memWrtEn && w_sel == SEL_HEX)  r_hex  <= memWrtData[15:0];
            if (memWrtEn && w_sel == SEL_LEDR) r_ledr <= memWrtData[9:0];
            if (memWrtEn && w_sel == SEL_LEDG) r_ledg <= memWrtData[7:0];
            r_key_sync1 <= keyIn;
            r_key_sync2 <= r_key_sync1;
            r_key_prev  <= w_key_now;
            // OR-ing the rise after the clear makes a new press win over a same-cycle clear.
            r_key_flags <= (r_key_flags & ~w_key_clr) | w_key_rise;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sw_sync1  <= '0;
            r_sw_sync   <= '0;
            r_sw_last   <= '0;
            r_sw_stable <= '0;
            r_dbcnt     <= '0;
        end else begin
            r_sw_sync1 <= swIn;
            r_sw_sync  <= r_sw_sync1;
            r_sw_last  <= r_sw_sync;
            if (r_sw_sync == r_sw_stable || r_sw_sync != r_sw_last) begin
                r_dbcnt <= '0;
            end else if (r_dbcnt == CNT_LAST) begin
                r_sw_stable <= r_sw_sync;
                r_dbcnt     <= '0;
            end else begin
                r_dbcnt <= r_dbcnt + 1'b1;
            end
        end
    end

    always_comb begin
        memRdData = '0;
        case (w_sel)
            SEL_RAM:     memRdData = w_ram_rd;
            SEL_HEX:     memRdData = {16'h0, r_hex};
            SEL_LEDR:    memRdData = {22'h0, r_ledr};
            SEL_LEDG:    memRdData = {24'h0, r_ledg};
            SEL_KEY:     memRdData = {28'h0, w_key_now};
            SEL_SW:      memRdData = {22'h0, r_sw_stable};
            SEL_KEYCTRL: memRdData = {28'h0, r_key_flags};
            default:     memRdData = '0;
        endcase
    end

    logic [6:0] w_seg [4];

    for (genvar gi = 0; gi < 4; gi++) begin : g_hex
        seven_seg_decoder u_dec (
            .i_nibble (r_hex[gi*4 +: 4]),
            .o_seg    (w_seg[gi])
        );
    end

    assign hex0 = w_seg[0];
    assign hex1 = w_seg[1];
    assign hex2 = w_seg[2];
    assign hex3 = w_seg[3];
    assign ledr = r_ledr;
    assign ledg = r_ledg;

endmodule
